// File: rtl/demux1a2_dest_cond_pkg.sv
// Shared definitions for the destination demux: word geometry, destination
// encodings (common with the 2:1 destination mux) and FSM state encoding.
package demux1a2_dest_cond_pkg;

  localparam int DATA_W   = 10;
  localparam int DEST_BIT = 8;
  localparam int CNT_W    = 8;

  localparam logic DEST0 = 1'b0;
  localparam logic DEST1 = 1'b1;

  typedef enum logic {
    PASS  = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/demux1a2_dest_cond_push_counter.sv
// Free-running push counter; wraps modulo 2^CNT_W, never saturates.
module push_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_count <= '0;
    else if (inc) r_count <= r_count + ONE;
  end

  assign count = r_count;

endmodule

// File: rtl/demux1a2_dest_cond.sv
// 1:2 destination demux: routes each word by one data bit, with a single hold
// register absorbing a word blocked by its destination's almost_full.
module demux1a2_dest_cond
  import demux1a2_dest_cond_pkg::*;
#(
  parameter int P_DATA_W   = DATA_W,
  parameter int P_DEST_BIT = DEST_BIT,
  parameter int P_CNT_W    = CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [P_DATA_W-1:0] data_in,
  output logic                ready_in,
  input  logic                almost_full0,
  input  logic                almost_full1,
  output logic                push0,
  output logic [P_DATA_W-1:0] data_out0,
  output logic                push1,
  output logic [P_DATA_W-1:0] data_out1,
  output logic [P_CNT_W-1:0]  cnt_dest0,
  output logic [P_CNT_W-1:0]  cnt_dest1
);

  state_t              r_state;
  logic [P_DATA_W-1:0] r_hold_data;
  logic                r_hold_dest;
  logic                r_push0;
  logic                r_push1;
  logic [P_DATA_W-1:0] r_data0;
  logic [P_DATA_W-1:0] r_data1;

  state_t              w_state_nxt;
  logic                w_in_dest;
  logic                w_in_af;
  logic                w_hold_af;
  logic                w_hold_load;
  logic                w_rel_go;
  logic                w_rel_dest;
  logic [P_DATA_W-1:0] w_rel_data;
  logic                w_push0_nxt;
  logic                w_push1_nxt;
  logic [P_DATA_W-1:0] w_data0_nxt;
  logic [P_DATA_W-1:0] w_data1_nxt;

  assign w_in_dest = data_in[P_DEST_BIT];
  assign w_in_af   = (w_in_dest == DEST1) ? almost_full1 : almost_full0;
  assign w_hold_af = (r_hold_dest == DEST1) ? almost_full1 : almost_full0;

  // Depends on state alone so upstream never sees a combinational loop.
  assign ready_in = (r_state == PASS);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_load = 1'b0;
    w_rel_go    = 1'b0;
    w_push0_nxt = 1'b0;
    w_push1_nxt = 1'b0;
    w_data0_nxt = '0;
    w_data1_nxt = '0;
    w_rel_dest  = (r_state == PASS) ? w_in_dest : r_hold_dest;
    w_rel_data  = (r_state == PASS) ? data_in : r_hold_data;

    unique case (r_state)
      PASS: begin
        if (valid_in) begin
          if (w_in_af) begin
            w_hold_load = 1'b1;
            w_state_nxt = STALL;
          end else begin
            w_rel_go = 1'b1;
          end
        end
      end
      STALL: begin
        // Only the held word's destination matters; no bypass for later words.
        if (!w_hold_af) begin
          w_rel_go    = 1'b1;
          w_state_nxt = PASS;
        end
      end
      default: w_state_nxt = PASS;
    endcase

    if (w_rel_go) begin
      if (w_rel_dest == DEST1) begin
        w_push1_nxt = 1'b1;
        w_data1_nxt = w_rel_data;
      end else begin
        w_push0_nxt = 1'b1;
        w_data0_nxt = w_rel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= PASS;
      r_hold_data <= '0;
      r_hold_dest <= DEST0;
      r_push0     <= 1'b0;
      r_push1     <= 1'b0;
      r_data0     <= '0;
      r_data1     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_load) begin
        r_hold_data <= data_in;
        r_hold_dest <= w_in_dest;
      end
      r_push0 <= w_push0_nxt;
      r_push1 <= w_push1_nxt;
      r_data0 <= w_data0_nxt;
      r_data1 <= w_data1_nxt;
    end
  end

  assign push0     = r_push0;
  assign push1     = r_push1;
  assign data_out0 = r_data0;
  assign data_out1 = r_data1;

  push_counter #(.CNT_W(P_CNT_W)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (r_push0),
    .count (cnt_dest0)
  );

  push_counter #(.CNT_W(P_CNT_W)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (r_push1),
    .count (cnt_dest1)
  );

endmodule

// File: tb/tb_demux1a2_dest_cond.sv
// Scoreboard bench for demux1a2_dest_cond: a behavioural model predicts each
// push (cycle, destination, word); a negedge monitor pops and compares.
module tb_demux1a2_dest_cond;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [9:0] data_in = '0;
  logic       ready_in;
  logic       almost_full0 = 1'b0;
  logic       almost_full1 = 1'b0;
  logic       push0, push1;
  logic [9:0] data_out0, data_out1;
  logic [7:0] cnt_dest0, cnt_dest1;

  demux1a2_dest_cond dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_in     (ready_in),
    .almost_full0 (almost_full0),
    .almost_full1 (almost_full1),
    .push0        (push0),
    .data_out0    (data_out0),
    .push1        (push1),
    .data_out1    (data_out1),
    .cnt_dest0    (cnt_dest0),
    .cnt_dest1    (cnt_dest1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] word;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       m_pend = 1'b0;
  logic [9:0] m_pend_word = '0;
  logic       m_ready = 1'b1;
  logic       m_acc = 1'b0;
  logic [7:0] m_cnt0 = '0;
  logic [7:0] m_cnt1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic af_of(input logic [9:0] w);
    return w[8] ? almost_full1 : almost_full0;
  endfunction

  // Reference model: one word may wait; it leaves when its FIFO is not almost
  // full. New words are taken only when nothing waits. Push is seen next cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend  = 1'b0;
      m_ready = 1'b1;
      m_acc   = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_acc = valid_in && !m_pend;
      if (m_pend) begin
        if (!af_of(m_pend_word)) begin
          exp_q.push_back('{cyc, m_pend_word});
          m_pend = 1'b0;
        end
      end else if (valid_in) begin
        if (!af_of(data_in)) exp_q.push_back('{cyc, data_in});
        else begin
          m_pend      = 1'b1;
          m_pend_word = data_in;
        end
      end
      m_ready = !m_pend;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      exp_t e;
      chk("ready_in", 32'(ready_in), 32'(m_ready));
      chk("cnt_dest0", 32'(cnt_dest0), 32'(m_cnt0));
      chk("cnt_dest1", 32'(cnt_dest1), 32'(m_cnt1));
      if (push0 && push1) chk("one_push", 32'(push0 & push1), 32'd0);
      if (push0 || push1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_push", {30'd0, push1, push0}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("push_cycle", 32'(cyc), 32'(e.cyc));
          chk("push_dest", 32'(push1), 32'(e.word[8]));
          chk("push_word", 32'(push1 ? data_out1 : data_out0), 32'(e.word));
          chk("idle_data", 32'(push1 ? data_out0 : data_out1), 32'd0);
        end
      end else begin
        if (data_out0 != 0 || data_out1 != 0)
          chk("idle_data", {6'd0, data_out1, 6'd0, data_out0}, 32'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          chk("missing_push", 32'd0, {22'd0, e.word});
        end
      end
      if (push0) m_cnt0 = m_cnt0 + 8'd1;
      if (push1) m_cnt1 = m_cnt1 + 8'd1;
    end
  end

  // Called at a negedge; returns at a negedge with valid_in dropped.
  task automatic send(input logic [9:0] d, input logic a0, input logic a1, input int rel);
    int t = 0;
    valid_in = 1'b1; data_in = d; almost_full0 = a0; almost_full1 = a1;
    forever begin
      @(posedge clk); #1;
      if (m_acc) break;
      t++;
      if (t > 50) begin
        chk("accept_timeout", 32'(t), 32'd0);
        break;
      end
      @(negedge clk);
      if (t >= rel) begin almost_full0 = 1'b0; almost_full1 = 1'b0; end
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n, input logic a0, input logic a1);
    valid_in = 1'b0; almost_full0 = a0; almost_full1 = a1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_push"}, {30'd0, push1, push0}, 32'd0);
    chk({tag, "_data"}, {12'd0, data_out1, data_out0}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, cnt_dest1, cnt_dest0}, 32'd0);
    chk({tag, "_ready"}, 32'(ready_in), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("reset_init");
    @(negedge clk);

    // Routing: back-to-back words to each destination.
    valid_in = 1'b1; data_in = 10'h005;
    @(negedge clk); data_in = 10'h105;
    @(negedge clk); valid_in = 1'b0;
    idle(2, 1'b0, 1'b0);

    // Stall on dest1, released after three cycles.
    send(10'h1AA, 1'b0, 1'b1, 99);
    idle(3, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b0);

    // Order: a dest0 word waits behind a stalled dest1 word.
    send(10'h101, 1'b0, 1'b1, 99);
    send(10'h002, 1'b0, 1'b1, 3);
    idle(2, 1'b0, 1'b0);

    // Independence: dest0 almost full does not block a dest1 word.
    send(10'h105, 1'b1, 1'b0, 99);
    idle(2, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      send(10'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'($urandom), 1'($urandom));
    end
    idle(3, 1'b0, 1'b0);

    // Reset while a word is held: it must vanish.
    send(10'h1F0, 1'b0, 1'b1, 99);
    idle(1, 1'b0, 1'b1);
    reset = 1'b1;
    #1 check_reset_outputs("reset_mid");
    idle(2, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_post");
    idle(2, 1'b0, 1'b0);

    // Wrap: 256 dest0 words from a zeroed counter.
    for (int i = 0; i < 256; i++) begin
      send(10'($urandom) & 10'h2FF, 1'b0, 1'b0, 99);
      if (i == 254) begin
        @(negedge clk);
        chk("cnt0_255", 32'(cnt_dest0), 32'd255);
      end
    end
    idle(2, 1'b0, 1'b0);
    chk("cnt0_wrap", 32'(cnt_dest0), 32'd0);
    chk("cnt1_unchanged", 32'(cnt_dest1), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
